// File: rtl/dr_sync_sink.sv
// dr_sync_sink: receives two-phase dual-rail words from an asynchronous
// upstream generator. It synchronizes every rail, waits for a complete and
// stable word, decodes it into a first-word-fall-through output FIFO and
// returns a two-phase acknowledge. A rail pair that toggles on both rails
// latches a sticky error and stops the block until reset.
module dr_sync_sink #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0][1:0] in,
    output logic                  ack_o,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_WAIT    = 2'd0,
        S_CONFIRM = 2'd1,
        S_CAPTURE = 2'd2,
        S_ERR     = 2'd3
    } state_t;

    // Reset: asserts together with rst, releases two clk edges after rst rises
    logic rst_meta_q;
    logic rst_sync_q;

    // Rail synchronizers
    logic [WIDTH-1:0][1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0][1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0][1:0] rails;

    // Protocol state
    state_t                state_q, state_d;
    logic [WIDTH-1:0][1:0] ref_q, ref_d;
    logic [WIDTH-1:0][1:0] prev_q, prev_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;

    // Completion detection
    logic [WIDTH-1:0][1:0] diff;
    logic                  word_complete;
    logic                  any_both;
    logic [WIDTH-1:0]      cap_word;

    // Output FIFO
    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push;
    logic                  pop;
    logic                  fifo_room;

    // Reset synchronizer: asynchronous assert, synchronous release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    // Synchronizer chain inputs: stage 0 is the only logic that samples in
    always_comb begin
        sync_d[0] = in;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // Synchronizer chain flops
    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
        end
    end

    assign rails = sync_q[SYNC_STAGES-1];

    // Per-bit completion against the last accepted rail state, plus decode
    // of the confirmed word held in prev_q
    always_comb begin
        diff          = rails ^ ref_q;
        word_complete = 1'b1;
        any_both      = 1'b0;
        cap_word      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (diff[i][1] == diff[i][0]) begin
                word_complete = 1'b0;
            end
            if (diff[i][1] && diff[i][0]) begin
                any_both = 1'b1;
            end
            cap_word[i] = prev_q[i][1] ^ ref_q[i][1];
        end
    end

    // FIFO status; a pop in the same cycle frees a slot for a full FIFO
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign fifo_room = (count_q != FULL_CNT) | pop;
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT: begin
                if (any_both) begin
                    state_d = S_ERR;
                end else if (word_complete) begin
                    state_d = S_CONFIRM;
                end
            end
            S_CONFIRM: begin
                if (any_both) begin
                    state_d = S_ERR;
                end else if ((rails != prev_q) || !word_complete) begin
                    state_d = S_WAIT;
                end else if (fifo_room) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: state_d = S_WAIT;
            default:   state_d = S_ERR;
        endcase
    end

    // FSM outputs: ack flips on entry to CAPTURE, the word and reference
    // are committed during CAPTURE from the confirmed rail snapshot
    always_comb begin
        push   = (state_q == S_CAPTURE);
        ack_d  = ack_q ^ ((state_q == S_CONFIRM) && (state_d == S_CAPTURE));
        err_d  = err_q | (state_d == S_ERR);
        ref_d  = push ? prev_q : ref_q;
        prev_d = rails;
    end

    // FIFO pointer and occupancy update; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(push);
        rd_ptr_d = rd_ptr_q + ADDR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q  <= S_WAIT;
            ref_q    <= '0;
            prev_q   <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            ref_q    <= ref_d;
            prev_q   <= prev_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cap_word;
        end
    end

    assign ack_o = ack_q;
    assign err   = err_q;

endmodule

// File: tb/tb_dr_sync_sink.sv
// tb_dr_sync_sink: directed bench for dr_sync_sink with a two-phase
// dual-rail upstream model, an expected-word queue filled as words are
// issued, and a monitor that pops and compares on every output handshake.
module tb_dr_sync_sink;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int SYNC_STAGES = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [WIDTH-1:0][1:0] up_rails = '0;
    logic                  ack_o;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic                  err;

    logic                  ready_cmd = 1'b0;
    logic                  rnd_en = 1'b0;
    logic                  ack_seen = 1'b0;
    logic [31:0]           exp_q[$];
    int                    n_vec = 0;
    int                    n_bad = 0;

    dr_sync_sink #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (up_rails),
        .ack_o     (ack_o),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Consumer ready: either commanded level or random
    always @(posedge clk) begin
        #1;
        out_ready = rnd_en ? 1'($urandom_range(0, 1)) : ready_cmd;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Output monitor: every accepted word must match the queue head
    always @(negedge clk) begin
        logic [31:0] w;
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL out_word: got %h, expected no word", out_data);
            end else begin
                w = exp_q.pop_front();
                check("out_word", out_data, w);
            end
        end
    end

    // Toggle one rail per selected bit: rail[1] for a 1, rail[0] for a 0
    task automatic drive_bits(input logic [31:0] w, input logic [31:0] mask);
        for (int i = 0; i < WIDTH; i++) begin
            if (mask[i]) begin
                if (w[i]) up_rails[i][1] = ~up_rails[i][1];
                else      up_rails[i][0] = ~up_rails[i][0];
            end
        end
    endtask

    task automatic wait_ack(input int bound, output logic got);
        got = 1'b0;
        for (int c = 0; c < bound; c++) begin
            @(posedge clk); #1;
            if (ack_o != ack_seen) begin
                got = 1'b1;
                ack_seen = ack_o;
                break;
            end
        end
    endtask

    task automatic drain(input int bound);
        for (int c = 0; c < bound; c++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) break;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst = 1'b0;
        up_rails = '0;
        exp_q.delete();
        ack_seen = 1'b0;
        #1;
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("rel_ack", 32'(ack_o), 32'd0);
        check("rel_valid", 32'(out_valid), 32'd0);
        check("rel_err", 32'(err), 32'd0);
        repeat (4) @(posedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic got;
        int   ack_lat;
        int   val_lat;
        int   err_lat;
        logic [31:0] fib [8];
        fib = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13};

        do_reset();

        // Single word, latency of ack and out_valid
        ready_cmd = 1'b1;
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        exp_q.push_back(32'h0000_0001);
        drive_bits(32'h0000_0001, 32'hFFFF_FFFF);
        ack_lat = 0;
        val_lat = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (ack_lat == 0 && ack_o != ack_seen) ack_lat = c;
            if (val_lat == 0 && out_valid) val_lat = c;
        end
        ack_seen = ack_o;
        check("ack_latency", 32'(ack_lat), 32'(SYNC_STAGES + 2));
        check("valid_latency", 32'(val_lat), 32'(SYNC_STAGES + 3));
        check("ack_level", 32'(ack_o), 32'd1);
        check("err_clear", 32'(err), 32'd0);
        drain(10);

        // Staggered bit arrival over ten cycles
        exp_q.push_back(32'hA5C3_0F96);
        for (int g = 0; g < 4; g++) begin
            logic [31:0] m;
            m = '0;
            for (int i = 0; i < WIDTH; i++) if ((i % 4) == g) m[i] = 1'b1;
            if (g == 3) check("skew_no_early_ack", 32'(ack_o), 32'(ack_seen));
            drive_bits(32'hA5C3_0F96, m);
            repeat ((g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 5 : 0) @(posedge clk);
            #1;
        end
        wait_ack(20, got);
        check("skew_ack", 32'(got), 32'd1);
        drain(20);

        // Backpressure: four words fill the FIFO, fifth waits unacknowledged
        ready_cmd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 1; k <= 5; k++) begin
            exp_q.push_back(32'(k));
            drive_bits(32'(k), 32'hFFFF_FFFF);
            wait_ack(30, got);
            check("full_ack", 32'(got), (k <= 4) ? 32'd1 : 32'd0);
        end
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_head", out_data, 32'd1);
        ready_cmd = 1'b1;
        wait_ack(30, got);
        check("release_ack", 32'(got), 32'd1);
        drain(60);

        // Both rails of bit 3 toggle: sticky error, block frozen
        @(posedge clk); #1;
        up_rails[3] = ~up_rails[3];
        err_lat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (err_lat == 0 && err) err_lat = c;
        end
        check("err_latency", 32'(err_lat), 32'(SYNC_STAGES + 1));
        drive_bits(32'h0000_00F0, 32'hFFFF_FFF7);
        wait_ack(20, got);
        check("err_no_ack", 32'(got), 32'd0);
        check("err_no_write", 32'(out_valid), 32'd0);
        check("err_sticky", 32'(err), 32'd1);

        // Reset with two queued words and a partial word in flight
        do_reset();
        ready_cmd = 1'b1;
        exp_q.push_back(32'hCAFE_0001);
        drive_bits(32'hCAFE_0001, 32'hFFFF_FFFF);
        wait_ack(20, got);
        check("pre_ack", 32'(got), 32'd1);
        drain(20);
        ready_cmd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(32'h0000_0011);
        drive_bits(32'h0000_0011, 32'hFFFF_FFFF);
        wait_ack(20, got);
        exp_q.push_back(32'h0000_0022);
        drive_bits(32'h0000_0022, 32'hFFFF_FFFF);
        wait_ack(20, got);
        drive_bits(32'h3333_3333, 32'h0000_FFFF);
        repeat (3) @(posedge clk);
        #1;
        check("queued_valid", 32'(out_valid), 32'd1);
        check("queued_ack", 32'(ack_o), 32'd1);
        do_reset();
        ready_cmd = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(32'h1234_5678);
        drive_bits(32'h1234_5678, 32'hFFFF_FFFF);
        wait_ack(20, got);
        check("post_rst_ack", 32'(got), 32'd1);
        drain(20);

        // Fibonacci stream with random consumer
        rnd_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(fib[k]);
            drive_bits(fib[k], 32'hFFFF_FFFF);
            wait_ack(60, got);
            check("fib_ack", 32'(got), 32'd1);
        end
        rnd_en = 1'b0;
        ready_cmd = 1'b1;
        drain(100);
        check("fib_err", 32'(err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dr_sync_sink.md
DR_SYNC_SINK -- requirements
Module: dr_sync_sink

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: number of data bits per word.
REQ-002 The block SHALL have parameter DEPTH, default 4: output FIFO entries, power of two, >=2.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2: synchronizer flops per rail, >=2.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (0 = reset), synchronous deassert to clk.
REQ-006 in  input  [WIDTH-1:0][1:0]  two-phase dual-rail data from the upstream generator; rail[1] toggle = 1, rail[0] toggle = 0.
REQ-007 ack_o  output  1  two-phase acknowledge to upstream; each toggle completes one word.
REQ-008 out_data  output  WIDTH  single-rail decoded word at FIFO head.
REQ-009 out_valid  output  1  FIFO head holds a word.
REQ-010 out_ready  input  1  consumer accepts head when out_valid & out_ready at clk edge.
REQ-011 err  output  1  sticky protocol-violation flag.

Function
REQ-012 Every rail of in SHALL pass through SYNC_STAGES flops before any use; no other logic SHALL sample in.
REQ-013 The block SHALL hold a reference vector ref[WIDTH-1:0][1:0] equal to the last accepted rail state.
REQ-014 Bit i SHALL be complete when exactly one of its synced rails differs from ref[i]; the word SHALL be complete when all WIDTH bits are complete.
REQ-015 Any bit with both rails differing from ref SHALL set err and move the FSM to ERR.
REQ-016 FSM states: WAIT, CONFIRM, CAPTURE, ERR; reset state WAIT.
REQ-017 WAIT -> CONFIRM on word complete; otherwise stay.
REQ-018 CONFIRM -> CAPTURE if synced rails identical to the previous cycle, still complete and FIFO not full; stays in CONFIRM while FIFO full; -> WAIT if synced rails changed.
REQ-019 CAPTURE SHALL, in one cycle, write decoded word (bit i = 1 iff rail[1] toggled) to FIFO, load ref from synced rails, toggle ack_o, return to WAIT.
REQ-020 ERR SHALL be terminal until reset; no FIFO writes, ack_o frozen.
REQ-021 ack_o SHALL be a flop output, toggling exactly once per captured word.
REQ-022 Latency from last rail transition to out_valid (FIFO empty) SHALL be SYNC_STAGES+3 clk cycles; to ack_o toggle SHALL be SYNC_STAGES+2.
REQ-023 FIFO SHALL be first-word-fall-through; out_data stable while out_valid & !out_ready.
REQ-024 Simultaneous write and read SHALL succeed when full (read frees slot same cycle; CONFIRM advances) and when empty (word appears next cycle).
REQ-025 FIFO pointers SHALL wrap modulo DEPTH; occupancy 0..DEPTH with no loss or duplication.
REQ-026 Sustained throughput SHALL be at most one word per SYNC_STAGES+3 cycles, bounded by the upstream round trip.

Reset
REQ-027 While rst = 0: ack_o = 0, out_valid = 0, out_data = 0, err = 0, ref = all 0, synchronizer flops = 0, FIFO empty, FSM = WAIT.
REQ-028 Reset mid-word SHALL discard partial words and FIFO contents; upstream SHALL be held in reset concurrently so rails return to all 0.
REQ-029 The first clk edge after rst deassertion SHALL observe all outputs at reset values.

Verification
REQ-030 Reset, then upstream toggles rails for word 0x00000001 with out_ready = 1 -> ack_o 0->1 after 4 cycles, out_valid for 1 cycle with out_data = 0x00000001, err = 0.
REQ-031 Bits toggled with staggered skew up to 10 cycles across WIDTH -> no capture until last bit complete; single word, correct value.
REQ-032 out_ready = 0, send 5 words with DEPTH = 4 -> 4 acks, 5th held in CONFIRM without ack; raise out_ready -> words 1..5 emerge in order.
REQ-033 Toggle both rails of bit 3 -> err = 1 within SYNC_STAGES+1 cycles, no further acks or writes, until rst low.
REQ-034 Assert rst low with 2 words queued and partial word in flight -> out_valid = 0, ack_o = 0 immediately; after release next full word captured correctly.
REQ-035 Fibonacci stream 0,1,1,2,3,5,8,13 with random out_ready -> identical sequence at out_data, one ack_o toggle per word.
